if_id_imm_stage: RTL and testbench

//  IF/ID pipeline register for the pipelined ARM64 core: captures fetched instruction + PC, supports

---
 rtl/if_id_imm_stage.sv | 139 +++++++++++++
 tb/tb_if_id_imm_stage.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/if_id_imm_stage.sv
// ---------------------------------------------------------------------------
// if_id_imm_stage
//   IF/ID pipeline register for the pipelined ARM64 core. It captures the
//   fetched instruction and its PC, and it supports two controls:
//     - stall: hold the stage contents.
//     - flush: insert a bubble.
//   It also classifies the immediate format of the instruction it captures.
//   The raw immediate field is presented right-aligned for the decode-stage
//   sign-extend units. A saturating counter tracks flush-inserted bubbles.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   stall        hold every stage register
//   flush        replace stage contents with a bubble (wins over stall)
//   pc_in        PC of the fetched instruction
//   instr_in     fetched instruction
//   fetch_valid  pc_in/instr_in carry a real instruction
//   pc_q         registered PC
//   instr_q      registered instruction (NOP when holding a bubble)
//   valid_q      registered instruction is real
//   imm_type     0 none, 1 DAddr9, 2 ALU_Imm12, 3 CondAddr19, 4 BrAddr26
//   imm_raw      selected immediate field, right-aligned, upper bits zero
//   bubble_cnt   saturating count of flush-inserted bubbles
// ---------------------------------------------------------------------------
module if_id_imm_stage #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [ADDR_WIDTH-1:0]  pc_in,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic                   fetch_valid,
  output logic [ADDR_WIDTH-1:0]  pc_q,
  output logic [INSTR_WIDTH-1:0] instr_q,
  output logic                   valid_q,
  output logic [2:0]             imm_type,
  output logic [25:0]            imm_raw,
  output logic [CNT_WIDTH-1:0]   bubble_cnt
);

  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_D9   = 3'd1;
  localparam logic [2:0] IMM_I12  = 3'd2;
  localparam logic [2:0] IMM_C19  = 3'd3;
  localparam logic [2:0] IMM_B26  = 3'd4;

  logic [ADDR_WIDTH-1:0]  pc_d;
  logic [INSTR_WIDTH-1:0] instr_d;
  logic                   valid_d;
  logic [2:0]             imm_type_d;
  logic [25:0]            imm_raw_d;
  logic [CNT_WIDTH-1:0]   bubble_cnt_d;

  // Immediate decode of the incoming instruction. The decode happens before
  // the register, so imm_type/imm_raw always describe the instruction in
  // instr_q. Opcode checks are in priority order, and the first match wins.
  logic [2:0]  dec_type;
  logic [25:0] dec_raw;

  always_comb begin
    dec_type = IMM_NONE;
    dec_raw  = '0;
    if (instr_in[31:26] == 6'b000101) begin
      dec_type = IMM_B26;
      dec_raw  = instr_in[25:0];
    end else if (instr_in[31:24] == 8'b10110100 ||
                 instr_in[31:24] == 8'b01010100) begin
      dec_type = IMM_C19;
      dec_raw  = {7'd0, instr_in[23:5]};
    end else if (instr_in[31:21] == 11'b11111000010 ||
                 instr_in[31:21] == 11'b11111000000) begin
      dec_type = IMM_D9;
      dec_raw  = {17'd0, instr_in[20:12]};
    end else if (instr_in[31:22] == 10'b1001000100 ||
                 instr_in[31:22] == 10'b1101000100) begin
      dec_type = IMM_I12;
      dec_raw  = {14'd0, instr_in[21:10]};
    end
  end

  // Next-state selection. Flush outranks stall, and stall outranks load.
  // A load with fetch_valid low still takes the new PC but stores a bubble.
  always_comb begin
    pc_d         = pc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    imm_type_d   = imm_type;
    imm_raw_d    = imm_raw;
    bubble_cnt_d = bubble_cnt;
    if (flush) begin
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;
      imm_type_d = IMM_NONE;
      imm_raw_d  = '0;
      // Saturate at all-ones so the counter never wraps back to zero.
      if (bubble_cnt != {CNT_WIDTH{1'b1}})
        bubble_cnt_d = bubble_cnt + 1'b1;
    end else if (!stall) begin
      pc_d = pc_in;
      if (fetch_valid) begin
        instr_d    = instr_in;
        valid_d    = 1'b1;
        imm_type_d = dec_type;
        imm_raw_d  = dec_raw;
      end else begin
        instr_d    = NOP_INSTR;
        valid_d    = 1'b0;
        imm_type_d = IMM_NONE;
        imm_raw_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= '0;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      imm_type   <= IMM_NONE;
      imm_raw    <= '0;
      bubble_cnt <= '0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      imm_type   <= imm_type_d;
      imm_raw    <= imm_raw_d;
      bubble_cnt <= bubble_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_id_imm_stage.sv
module tb_if_id_imm_stage;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset, stall, flush, fetch_valid;
  logic [63:0] pc_in;
  logic [31:0] instr_in;

  logic [63:0] pc_q,  pc_q2;
  logic [31:0] instr_q, instr_q2;
  logic        valid_q, valid_q2;
  logic [2:0]  imm_type, imm_type2;
  logic [25:0] imm_raw, imm_raw2;
  logic [15:0] bubble_cnt;
  logic [1:0]  bubble_cnt2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  if_id_imm_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .pc_in(pc_in), .instr_in(instr_in), .fetch_valid(fetch_valid),
    .pc_q(pc_q), .instr_q(instr_q), .valid_q(valid_q),
    .imm_type(imm_type), .imm_raw(imm_raw), .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter instance that shares the stimulus, used for saturation.
  if_id_imm_stage #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .pc_in(pc_in), .instr_in(instr_in), .fetch_valid(fetch_valid),
    .pc_q(pc_q2), .instr_q(instr_q2), .valid_q(valid_q2),
    .imm_type(imm_type2), .imm_raw(imm_raw2), .bubble_cnt(bubble_cnt2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [63:0] pc, input logic [31:0] ins,
                           input logic v, input logic [2:0] t, input logic [25:0] r,
                           input logic [15:0] cnt);
    check({tag, ".pc"},    pc_q,       pc);
    check({tag, ".instr"}, instr_q,    ins);
    check({tag, ".valid"}, valid_q,    v);
    check({tag, ".type"},  imm_type,   t);
    check({tag, ".raw"},   imm_raw,    r);
    check({tag, ".cnt"},   bubble_cnt, cnt);
    $display("[TB] %s pc=%0h instr=%08h valid=%0b type=%0d raw=%0h cnt=%0d",
             tag, pc_q, instr_q, valid_q, imm_type, imm_raw, bubble_cnt);
  endtask

  // Decode vectors with hand-computed immediate classification.
  logic [31:0] vec_instr [7] = '{32'hB4000040, 32'h54000020, 32'hF8010020,
                                 32'hD1000400, 32'h8B020020, 32'h14000003, 32'hD503201F};
  logic [2:0]  vec_type  [7] = '{3'd3, 3'd3, 3'd1, 3'd2, 3'd0, 3'd4, 3'd0};
  logic [25:0] vec_raw   [7] = '{26'h2, 26'h1, 26'h10, 26'h1, 26'h0, 26'h3, 26'h0};
  logic [1:0]  sat_exp   [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; fetch_valid = 1'b0;
    pc_in = 64'h0; instr_in = 32'h0;

    // Reset held for two cycles.
    step(); step();
    check_all("reset", 64'h0, NOP, 1'b0, 3'd0, 26'h0, 16'd0);
    reset = 1'b1;

    // Load an unconditional branch.
    instr_in = 32'h17FFFFFF; pc_in = 64'h40; fetch_valid = 1'b1;
    step();
    check_all("b26", 64'h40, 32'h17FFFFFF, 1'b1, 3'd4, 26'h3FFFFFF, 16'd0);

    // Load an LDUR instruction.
    instr_in = 32'hF85F8041; pc_in = 64'h44;
    step();
    check_all("ldur", 64'h44, 32'hF85F8041, 1'b1, 3'd1, 26'h1F8, 16'd0);

    // Stall for three cycles while the inputs change; every output must hold.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_in = 32'h14000000 + i; pc_in = 64'h100 + 64'(i * 4); fetch_valid = i[0];
      step();
      check_all($sformatf("stall%0d", i), 64'h44, 32'hF85F8041, 1'b1, 3'd1, 26'h1F8, 16'd0);
    end

    // Flush with stall also high: flush wins and the PC holds.
    flush = 1'b1;
    step();
    check_all("flush_stall", 64'h44, NOP, 1'b0, 3'd0, 26'h0, 16'd1);
    check("sat0", bubble_cnt2, sat_exp[0]);
    stall = 1'b0;

    // Four more flushes: the wide counter keeps counting, the narrow one saturates.
    for (int i = 1; i < 5; i++) begin
      step();
      check($sformatf("cnt%0d", i), bubble_cnt, 64'(i + 1));
      check($sformatf("sat%0d", i), bubble_cnt2, sat_exp[i]);
      check($sformatf("flpc%0d", i), pc_q, 64'h44);
      $display("[TB] flush%0d cnt=%0d sat_cnt=%0d", i, bubble_cnt, bubble_cnt2);
    end
    flush = 1'b0;

    // Load an ADDI instruction, then a load with fetch_valid low.
    instr_in = 32'h910004A5; pc_in = 64'h48; fetch_valid = 1'b1;
    step();
    check_all("addi", 64'h48, 32'h910004A5, 1'b1, 3'd2, 26'h1, 16'd5);
    pc_in = 64'h4C; fetch_valid = 1'b0;
    step();
    check_all("novalid", 64'h4C, NOP, 1'b0, 3'd0, 26'h0, 16'd5);

    // Additional decode classes.
    fetch_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      instr_in = vec_instr[i]; pc_in = 64'h200 + 64'(i * 4);
      step();
      check_all($sformatf("dec%0d", i), 64'h200 + 64'(i * 4), vec_instr[i], 1'b1,
                vec_type[i], vec_raw[i], 16'd5);
    end

    // Reset asserted while stall and flush are both high: reset values win.
    reset = 1'b0; stall = 1'b1; flush = 1'b1;
    step();
    check_all("reset_mid", 64'h0, NOP, 1'b0, 3'd0, 26'h0, 16'd0);
    check("reset_mid.sat", bubble_cnt2, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
